decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue_if.sv | 28 ++
 rtl/decode_queue.sv | 121 ++++++++++++
 tb/tb_decode_queue.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// Handshake bundle between the decode mux, the decode queue and dispatch.
// The queue uses the slave modport; the upstream/dispatch side uses master.
interface decode_queue_if #(
  parameter int unsigned depth      = 8,
  parameter int unsigned entryWidth = 295
) ();
  localparam int unsigned CountWidth = $clog2(depth) + 1;

  logic                  flush_i;
  logic                  enable_i;
  logic [entryWidth-1:0] entry_i;
  logic                  stall_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [entryWidth-1:0] entry_o;
  logic [CountWidth-1:0] count_o;
  logic                  overflow_o;

  modport master (
    output flush_i, enable_i, entry_i, ready_i,
    input  stall_o, valid_o, entry_o, count_o, overflow_o
  );

  modport slave (
    input  flush_i, enable_i, entry_i, ready_i,
    output stall_o, valid_o, entry_o, count_o, overflow_o
  );
endinterface

// File: rtl/decode_queue.sv
// Circular decoded-instruction queue between the decode mux and dispatch.
// Define DECODE_QUEUE_STATS_EN to add the stallCycles_o / highWater_o statistics ports.
module decode_queue #(
  parameter int unsigned depth       = 8,
  parameter int unsigned stallMargin = 2,
  parameter int unsigned entryWidth  = 295
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  decode_queue_if.slave           q_if
`ifdef DECODE_QUEUE_STATS_EN
  ,
  output logic [31:0]             stallCycles_o,
  output logic [$clog2(depth):0]  highWater_o
`endif
);
  localparam int unsigned AddrWidth = $clog2(depth);
  localparam int unsigned PtrWidth  = AddrWidth + 1;

  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [entryWidth-1:0] storage_q [depth];

  logic full;
  logic valid;
  logic pop;
  logic push;
  logic stall;

  always_comb begin
    full  = (32'(count_q) == depth);
    valid = (count_q != '0);
    pop   = valid && q_if.ready_i;
    // A flush discards everything, so the same-cycle push never lands.
    push  = q_if.enable_i && (!full || pop) && !q_if.flush_i;
    stall = (32'(depth) - 32'(count_q)) <= 32'(stallMargin);
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (q_if.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrWidth'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrWidth'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + PtrWidth'(1);
        2'b01:   count_d = count_q - PtrWidth'(1);
        default: count_d = count_q;
      endcase
      if (q_if.enable_i && full && !pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never reset; entry_o is only meaningful while valid_o is high.
  always_ff @(posedge clock_i) begin
    if (reset_i && push) begin
      storage_q[wr_ptr_q[AddrWidth-1:0]] <= q_if.entry_i;
    end
  end

  assign q_if.valid_o    = valid;
  assign q_if.entry_o    = storage_q[rd_ptr_q[AddrWidth-1:0]];
  assign q_if.count_o    = count_q;
  assign q_if.overflow_o = overflow_q;
  assign q_if.stall_o    = stall;

`ifdef DECODE_QUEUE_STATS_EN
  logic [31:0]         stall_cycles_q, stall_cycles_d;
  logic [PtrWidth-1:0] high_water_q, high_water_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    high_water_d = (count_q > high_water_q) ? count_q : high_water_q;
  end

  // Statistics survive a flush; only reset clears them.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      stall_cycles_q <= '0;
      high_water_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      high_water_q   <= high_water_d;
    end
  end

  assign stallCycles_o = stall_cycles_q;
  assign highWater_o   = high_water_q;
`endif
endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: queue-based reference model, directed scenarios, random traffic.
module tb_decode_queue;
  localparam int DEPTH   = 8;
  localparam int MARGIN  = 2;
  localparam int EW      = 295;
  localparam int CW      = 4;
  localparam int MAJ_LSB = 104;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_queue_if #(.depth(DEPTH), .entryWidth(EW)) dq_if ();

`ifdef DECODE_QUEUE_STATS_EN
  logic [31:0]   stall_cycles;
  logic [CW-1:0] high_water;
`endif

  decode_queue #(.depth(DEPTH), .stallMargin(MARGIN), .entryWidth(EW)) dut (
    .clock_i       (clk),
    .reset_i       (rst_n),
    .q_if          (dq_if)
`ifdef DECODE_QUEUE_STATS_EN
    ,
    .stallCycles_o (stall_cycles),
    .highWater_o   (high_water)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain FIFO of entries plus sticky flags and stats.
  logic [EW-1:0] model_q[$];
  bit            model_ovf  = 1'b0;
  int            model_hw   = 0;
  logic [31:0]   model_sc   = '0;
  bit            model_live = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_entry(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_entry(input logic [63:0] maj);
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    mk_entry = r[EW-1:0];
    mk_entry[MAJ_LSB +: 64] = maj;
  endfunction

  function automatic logic [63:0] head_maj();
    return dq_if.entry_o[MAJ_LSB +: 64];
  endfunction

  always @(posedge clk) begin
    int  sz;
    bit  pop;
    if (!rst_n) begin
      model_q.delete();
      model_ovf  = 1'b0;
      model_hw   = 0;
      model_sc   = '0;
      model_live = 1'b1;
    end else begin
      sz = model_q.size();
      if ((DEPTH - sz) <= MARGIN && model_sc != 32'hffff_ffff) model_sc = model_sc + 32'd1;
      if (sz > model_hw) model_hw = sz;
      if (dq_if.flush_i) begin
        model_q.delete();
      end else begin
        pop = (sz > 0) && dq_if.ready_i;
        if (pop) void'(model_q.pop_front());
        if (dq_if.enable_i) begin
          if (sz < DEPTH || pop) model_q.push_back(dq_if.entry_i);
          else model_ovf = 1'b1;
        end
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      chk("count_o", 64'(dq_if.count_o), 64'(model_q.size()));
      chk("valid_o", 64'(dq_if.valid_o), 64'(model_q.size() != 0));
      chk("stall_o", 64'(dq_if.stall_o), 64'((DEPTH - model_q.size()) <= MARGIN));
      chk("overflow_o", 64'(dq_if.overflow_o), 64'(model_ovf));
      if (model_q.size() != 0) chk_entry("entry_o", dq_if.entry_o, model_q[0]);
`ifdef DECODE_QUEUE_STATS_EN
      chk("stallCycles_o", 64'(stall_cycles), 64'(model_sc));
      chk("highWater_o", 64'(high_water), 64'(model_hw));
`endif
    end
  end

  task automatic cyc(input bit en, input bit rd, input bit fl, input bit rs_n, input logic [63:0] maj);
    dq_if.enable_i = en;
    dq_if.ready_i  = rd;
    dq_if.flush_i  = fl;
    dq_if.entry_i  = mk_entry(maj);
    rst_n          = rs_n;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int en_pct;
    int rd_pct;
    dq_if.enable_i = 1'b0;
    dq_if.ready_i  = 1'b0;
    dq_if.flush_i  = 1'b0;
    dq_if.entry_i  = '0;

    // Reset state
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("reset_count", 64'(dq_if.count_o), 64'd0);
    chk("reset_valid", 64'(dq_if.valid_o), 64'd0);
    chk("reset_stall", 64'(dq_if.stall_o), 64'd0);
    chk("reset_ovf", 64'(dq_if.overflow_o), 64'd0);

    // Three pushes with dispatch blocked, then drain in order
    cyc(1, 0, 0, 1, 64'd1);
    chk("valid_after_first_push", 64'(dq_if.valid_o), 64'd1);
    cyc(1, 0, 0, 1, 64'd2);
    cyc(1, 0, 0, 1, 64'd3);
    chk("count_three", 64'(dq_if.count_o), 64'd3);
    for (int i = 1; i <= 3; i++) begin
      chk("order_head", head_maj(), 64'(i));
      cyc(0, 1, 0, 1, 0);
    end
    chk("drained_valid", 64'(dq_if.valid_o), 64'd0);

    // Fill to stall threshold, full, then overflow
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 64'(10 + i));
    chk("stall_at_5", 64'(dq_if.stall_o), 64'd0);
    cyc(1, 0, 0, 1, 64'd15);
    chk("count_6", 64'(dq_if.count_o), 64'd6);
    chk("stall_at_6", 64'(dq_if.stall_o), 64'd1);
    cyc(1, 0, 0, 1, 64'd16);
    cyc(1, 0, 0, 1, 64'd17);
    chk("count_full", 64'(dq_if.count_o), 64'd8);
    chk("ovf_before_9th", 64'(dq_if.overflow_o), 64'd0);
    cyc(1, 0, 0, 1, 64'd18);
    chk("ovf_after_9th", 64'(dq_if.overflow_o), 64'd1);
    chk("count_after_9th", 64'(dq_if.count_o), 64'd8);

    // Full queue with push and pop together
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 64'(11 + i));
    cyc(1, 1, 0, 1, 64'd100);
    chk("full_pushpop_count", 64'(dq_if.count_o), 64'd8);
    chk("full_pushpop_ovf", 64'(dq_if.overflow_o), 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk("full_pushpop_order", head_maj(), (i < 7) ? 64'(12 + i) : 64'd100);
      cyc(0, 1, 0, 1, 0);
    end

    // 20 interleaved pushes/pops across pointer wrap
    cyc(1, 0, 0, 1, 64'd200);
    for (int i = 1; i < 20; i++) begin
      cyc(1, 1, 0, 1, 64'(200 + i));
      chk("stream_count", 64'(dq_if.count_o), 64'd1);
      chk("stream_head", head_maj(), 64'(200 + i));
    end
    cyc(0, 1, 0, 1, 0);

    // Flush with concurrent push and pop at count 5
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 64'(300 + i));
    chk("pre_flush_count", 64'(dq_if.count_o), 64'd5);
    cyc(1, 1, 1, 1, 64'd399);
    chk("flush_count", 64'(dq_if.count_o), 64'd0);
    chk("flush_valid", 64'(dq_if.valid_o), 64'd0);
    cyc(0, 0, 0, 1, 0);
    chk("flush_push_lost", 64'(dq_if.valid_o), 64'd0);

    // Mid-operation reset at count 3, with overflow set beforehand
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 1, 64'(400 + i));
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0);
    chk("pre_reset_count", 64'(dq_if.count_o), 64'd3);
    chk("pre_reset_ovf", 64'(dq_if.overflow_o), 64'd1);
    cyc(1, 1, 0, 0, 64'd499);
    chk("midreset_count", 64'(dq_if.count_o), 64'd0);
    chk("midreset_valid", 64'(dq_if.valid_o), 64'd0);
    chk("midreset_stall", 64'(dq_if.stall_o), 64'd0);
    chk("midreset_ovf", 64'(dq_if.overflow_o), 64'd0);
`ifdef DECODE_QUEUE_STATS_EN
    chk("midreset_highwater", 64'(high_water), 64'd0);
`endif

    // Randomized traffic: fill-heavy, balanced, drain-heavy
    for (int ph = 0; ph < 3; ph++) begin
      en_pct = (ph == 0) ? 85 : (ph == 1) ? 50 : 25;
      rd_pct = (ph == 0) ? 30 : (ph == 1) ? 50 : 80;
      for (int i = 0; i < 600; i++) begin
        cyc($urandom_range(0, 99) < en_pct, $urandom_range(0, 99) < rd_pct,
            $urandom_range(0, 39) == 0, $urandom_range(0, 99) != 0, {32'h0, $urandom});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
